rr_arbiter_tree: RTL and testbench

- Round-robin arbiter with payload multiplexing: NumIn valid/ready request streams in, one arbitrated stream out.
- Forwards the winner's payload and index.
- Used per output port of stream crossbars and interconnects.
- Optional lock-in keeps a decision stable until the downstream handshake completes, for AXI-compliant valid/ready.

---
 rtl/rr_arbiter_pkg.sv | 22 ++
 rtl/rr_arbiter_pick.sv | 44 ++++
 rtl/rr_arbiter_tree.sv | 138 +++++++++++++
 tb/tb_rr_arbiter_tree.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : rr_arbiter_pkg                                                  |
// | Purpose  : Shared helpers for the rr_arbiter_tree slice.                   |
// |            idx_width(n) : index width for n requesters (min 1 bit).        |
// |            lock_ctl_t   : per-cycle lock capture/drop decision.            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package rr_arbiter_pkg;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Decision computed each cycle for the lock register pair (lock_q/sel_q).
  typedef struct packed {
    logic capture;  // output stalled: freeze the current index
    logic drop;     // output handshake: release the frozen index
  } lock_ctl_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rr_arbiter_pick                                                 |
// | Purpose  : Rotating first-one finder. Returns the first set request bit    |
// |            scanning ptr_i, ptr_i+1, ..., NUM_IN-1, 0, ..., ptr_i-1.        |
// |            With no request the winner is ptr_i.                            |
// | Ports    : req_i    [NUM_IN]  request vector                               |
// |            ptr_i    [IDX_W]   priority pointer (must be < NUM_IN)          |
// |            winner_o [IDX_W]   selected index                               |
// |            any_o              at least one request present                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module rr_arbiter_pick #(
  parameter int NUM_IN = 2,
  parameter int IDX_W  = 1
) (
  input  logic [NUM_IN-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [IDX_W-1:0]  winner_o,
  output logic              any_o
);

  // Lower half: requests at or above the pointer. Upper half: all requests,
  // which covers the wrap-around part of the scan.
  logic [2*NUM_IN-1:0] scan;

  always_comb begin
    for (int j = 0; j < NUM_IN; j++) begin
      scan[j]          = req_i[j] && (j >= int'(ptr_i));
      scan[NUM_IN + j] = req_i[j];
    end
    winner_o = ptr_i;
    // Descending walk so the lowest set bit of the doubled vector wins.
    for (int j = 2*NUM_IN-1; j >= 0; j--) begin
      if (scan[j]) begin
        winner_o = IDX_W'(j % NUM_IN);
      end
    end
  end

  assign any_o = |req_i;

endmodule
`default_nettype wire

// File: rtl/rr_arbiter_tree.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rr_arbiter_tree                                                 |
// | Purpose  : Round-robin arbiter with payload mux. NumIn valid/ready streams |
// |            in, one arbitrated stream out carrying payload and index.       |
// | Ports    : clk_i, rst_i (async, active-high), flush_i (sync state clear)   |
// |            rr_i    external priority pointer (ExtPrio=1)                   |
// |            req_i / gnt_o / data_i    input side valid/ready/payload        |
// |            req_o / gnt_i / data_o / idx_o  output side                     |
// | Options  : RR_ARBITER_TREE_ASSERT_EN enables simulation protocol checks.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module rr_arbiter_tree
  import rr_arbiter_pkg::*;
#(
  parameter int NumIn     = 2,
  parameter int DataWidth = 32,
  parameter int ExtPrio   = 0,
  parameter int AxiVldRdy = 1,
  parameter int LockIn    = 1,
  parameter int IdxWidth  = idx_width(NumIn)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic [IdxWidth-1:0]        rr_i,
  input  logic [NumIn-1:0]           req_i,
  output logic [NumIn-1:0]           gnt_o,
  input  logic [NumIn*DataWidth-1:0] data_i,
  output logic                       req_o,
  input  logic                       gnt_i,
  output logic [DataWidth-1:0]       data_o,
  output logic [IdxWidth-1:0]        idx_o
);

  if (NumIn == 1) begin : g_single
    // Single requester: pure passthrough, nothing to remember.
    assign req_o  = req_i[0];
    assign data_o = data_i;
    assign idx_o  = '0;
    assign gnt_o  = (AxiVldRdy != 0) ? gnt_i : (gnt_i & req_i[0]);
  end else begin : g_multi
    logic [IdxWidth-1:0] rr_q, rr_d;
    logic [IdxWidth-1:0] sel_q, sel_d;
    logic                lock_q, lock_d;
    logic [IdxWidth-1:0] ptr, winner, idx;
    logic                any;
    lock_ctl_t           ctl;

    // Out-of-range pointers fall back to 0.
    always_comb begin
      ptr = (ExtPrio != 0) ? rr_i : rr_q;
      if (int'(ptr) >= NumIn) begin
        ptr = '0;
      end
    end

    rr_arbiter_pick #(
      .NUM_IN (NumIn),
      .IDX_W  (IdxWidth)
    ) u_pick (
      .req_i    (req_i),
      .ptr_i    (ptr),
      .winner_o (winner),
      .any_o    (any)
    );

    // A stalled decision stays put until the downstream handshake.
    always_comb begin
      idx = ((LockIn != 0) && lock_q) ? sel_q : winner;
    end

    assign idx_o  = idx;
    assign req_o  = any;
    assign data_o = data_i[int'(idx)*DataWidth +: DataWidth];

    always_comb begin
      for (int i = 0; i < NumIn; i++) begin
        gnt_o[i] = gnt_i && (int'(idx) == i) && ((AxiVldRdy != 0) || req_i[i]);
      end
    end

    always_comb begin
      ctl.capture = (LockIn != 0) && any && !gnt_i;
      ctl.drop    = gnt_i;

      rr_d   = rr_q;
      lock_d = lock_q;
      sel_d  = sel_q;

      if ((ExtPrio == 0) && any && gnt_i) begin
        rr_d = (int'(idx) == NumIn-1) ? '0 : idx + IdxWidth'(1);
      end

      if (ctl.capture) begin
        lock_d = 1'b1;
        sel_d  = idx;
      end else if (ctl.drop) begin
        lock_d = 1'b0;
      end

      if (flush_i) begin
        rr_d   = '0;
        lock_d = 1'b0;
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        rr_q   <= '0;
        lock_q <= 1'b0;
        sel_q  <= '0;
      end else begin
        rr_q   <= rr_d;
        lock_q <= lock_d;
        sel_q  <= sel_d;
      end
    end
  end

`ifdef RR_ARBITER_TREE_ASSERT_EN
  a_num_in: assert property (@(posedge clk_i) NumIn > 0);

  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(gnt_o));

  a_lock_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    ((LockIn != 0) && req_o && !gnt_i) |=>
      (req_o && $stable(idx_o) && $stable(data_o)));

  a_rr_range: assert property (@(posedge clk_i) disable iff (rst_i)
    (ExtPrio == 0) || (int'(rr_i) < NumIn));
`else
  // Checkers compiled out; datapath unaffected.
`endif

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_tree.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_rr_arbiter_tree                                              |
// | Purpose  : Self-checking bench for rr_arbiter_tree (NumIn=4, DataWidth=8). |
// |            Three instances share stimulus: default config, AxiVldRdy=0,    |
// |            and ExtPrio=1.                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_rr_arbiter_tree;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        gnt = 1'b0;
  logic [1:0]  rr = '0;
  logic [3:0]  req = '0;
  logic [31:0] data = {8'h13, 8'h12, 8'h11, 8'h10};

  logic [3:0] gnt0, gnt1, gnt2;
  logic       req0, req1, req2;
  logic [7:0] dat0, dat1, dat2;
  logic [1:0] idx0, idx1, idx2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    int         dsel;
    logic       req_o;
    logic [3:0] gnt_o;
    logic [1:0] idx_o;
    logic [7:0] data_o;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  rr_arbiter_tree #(.NumIn(4), .DataWidth(8)) u_dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .rr_i(rr), .req_i(req),
    .gnt_o(gnt0), .data_i(data), .req_o(req0), .gnt_i(gnt),
    .data_o(dat0), .idx_o(idx0));

  rr_arbiter_tree #(.NumIn(4), .DataWidth(8), .AxiVldRdy(0)) u_dut_nr (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .rr_i(rr), .req_i(req),
    .gnt_o(gnt1), .data_i(data), .req_o(req1), .gnt_i(gnt),
    .data_o(dat1), .idx_o(idx1));

  rr_arbiter_tree #(.NumIn(4), .DataWidth(8), .ExtPrio(1)) u_dut_ext (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .rr_i(rr), .req_i(req),
    .gnt_o(gnt2), .data_i(data), .req_o(req2), .gnt_i(gnt),
    .data_o(dat2), .idx_o(idx2));

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic g, input logic f, input logic [1:0] p);
    req = r; gnt = g; flush = f; rr = p;
  endtask

  // Push the expectation, let outputs settle, then pop and compare.
  task automatic expect_now(input string tag, input int dsel, input logic er,
                            input logic [3:0] eg, input logic [1:0] ei);
    exp_t e;
    exp_t x;
    logic       o_req;
    logic [3:0] o_gnt;
    logic [1:0] o_idx;
    logic [7:0] o_dat;
    e.tag = tag; e.dsel = dsel; e.req_o = er; e.gnt_o = eg; e.idx_o = ei;
    e.data_o = 8'h10 + {6'd0, ei};
    sb.push_back(e);
    #1;
    x = sb.pop_front();
    case (x.dsel)
      1:       begin o_req = req1; o_gnt = gnt1; o_idx = idx1; o_dat = dat1; end
      2:       begin o_req = req2; o_gnt = gnt2; o_idx = idx2; o_dat = dat2; end
      default: begin o_req = req0; o_gnt = gnt0; o_idx = idx0; o_dat = dat0; end
    endcase
    check_val({x.tag, ".req"},  32'(o_req), 32'(x.req_o));
    check_val({x.tag, ".gnt"},  32'(o_gnt), 32'(x.gnt_o));
    check_val({x.tag, ".idx"},  32'(o_idx), 32'(x.idx_o));
    check_val({x.tag, ".data"}, 32'(o_dat), 32'(x.data_o));
  endtask

  task automatic step(input string tag, input logic [3:0] r, input logic g,
                      input logic f, input logic [1:0] p, input int dsel,
                      input logic er, input logic [3:0] eg, input logic [1:0] ei);
    @(negedge clk);
    drive(r, g, f, p);
    expect_now(tag, dsel, er, eg, ei);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(4'b0000, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    expect_now("rst", 0, 1'b0, 4'b0000, 2'd0);
    @(negedge clk);
    rst = 1'b0;

    step("idle", 4'b0000, 1'b0, 1'b0, 2'd0, 0, 1'b0, 4'b0000, 2'd0);

    // Fairness: all requesting, output always ready.
    for (int i = 0; i < 8; i++) begin
      step($sformatf("fair%0d", i), 4'b1111, 1'b1, 1'b0, 2'd0, 0,
           1'b1, 4'(1 << (i % 4)), 2'(i % 4));
    end

    // Lock-in: stalled decision on input 1 survives a new lower request.
    for (int i = 0; i < 3; i++) begin
      step($sformatf("lk%0d", i), 4'b0110, 1'b0, 1'b0, 2'd0, 0, 1'b1, 4'b0000, 2'd1);
    end
    step("lk_new",  4'b0111, 1'b0, 1'b0, 2'd0, 0, 1'b1, 4'b0000, 2'd1);
    step("lk_hs",   4'b0111, 1'b1, 1'b0, 2'd0, 0, 1'b1, 4'b0010, 2'd1);
    step("lk_next", 4'b0111, 1'b1, 1'b0, 2'd0, 0, 1'b1, 4'b0100, 2'd2);

    // Flush while locked on input 2: pointer and lock cleared.
    step("fl_set",   4'b0100, 1'b0, 1'b0, 2'd0, 0, 1'b1, 4'b0000, 2'd2);
    step("fl_on",    4'b0101, 1'b0, 1'b1, 2'd0, 0, 1'b1, 4'b0000, 2'd2);
    step("fl_after", 4'b0101, 1'b0, 1'b0, 2'd0, 0, 1'b1, 4'b0000, 2'd0);

    // Async reset mid-cycle while locked on input 3.
    step("pre_rst", 4'b0101, 1'b1, 1'b0, 2'd0, 0, 1'b1, 4'b0001, 2'd0);
    step("lk3",     4'b1000, 1'b0, 1'b0, 2'd0, 0, 1'b1, 4'b0000, 2'd3);
    step("held3",   4'b0101, 1'b0, 1'b0, 2'd0, 0, 1'b1, 4'b0000, 2'd3);
    #2 rst = 1'b1;
    expect_now("async_rst", 0, 1'b1, 4'b0000, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(4'b1111, 1'b1, 1'b0, 2'd0);
    expect_now("fresh", 0, 1'b1, 4'b0001, 2'd0);

    // Grant gating: AxiVldRdy=0 instance versus default instance.
    do_reset();
    step("nr_a", 4'b0100, 1'b1, 1'b0, 2'd0, 1, 1'b1, 4'b0100, 2'd2);
    expect_now("ax_a", 0, 1'b1, 4'b0100, 2'd2);
    do_reset();
    step("nr_b", 4'b0010, 1'b1, 1'b0, 2'd0, 1, 1'b1, 4'b0010, 2'd1);
    step("nr_idle", 4'b0000, 1'b1, 1'b0, 2'd0, 1, 1'b0, 4'b0000, 2'd2);
    expect_now("ax_idle", 0, 1'b0, 4'b0100, 2'd2);

    // External priority pointer; the internal register must not interfere.
    do_reset();
    step("ext3",  4'b1001, 1'b1, 1'b0, 2'd3, 2, 1'b1, 4'b1000, 2'd3);
    step("ext0",  4'b1001, 1'b1, 1'b0, 2'd0, 2, 1'b1, 4'b0001, 2'd0);
    step("ext0b", 4'b1001, 1'b1, 1'b0, 2'd0, 2, 1'b1, 4'b0001, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
